// File: rtl/test_systolic_mac.sv
`default_nettype none
// ============================================================================
// Module      : test_systolic_mac
// Description : 4x4 weight-stationary systolic MAC array. Skewed activations
//               enter the rows and partial sums flow down the columns. Each
//               column's bottom result is exposed raw, 8-bit saturated,
//               clamped to +/-LIMIT, activated and requantized.
//               Optional feature macro: RELU_EN (ReLU on the clamped sum).
// Revision    : 1.0 - initial release
// ============================================================================
module test_systolic_mac #(
  parameter int LIMIT  = 32767,
  parameter int RSHIFT = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic signed [7:0]  a11, a12, a13, a14,
  input  logic signed [7:0]  w11, w12, w13, w14,
  input  logic signed [7:0]  w21, w22, w23, w24,
  input  logic signed [7:0]  w31, w32, w33, w34,
  input  logic signed [7:0]  w41, w42, w43, w44,
  input  logic signed [23:0] carry_in,
  output logic signed [23:0] sum4, sum8, sum12, sum16,
  output logic        [7:0]  qsum4, qsum8, qsum12, qsum16,
  output logic signed [23:0] limited_sum4, limited_sum8, limited_sum12, limited_sum16,
  output logic signed [23:0] activated_sum4, activated_sum8, activated_sum12, activated_sum16,
  output logic        [7:0]  rsum4, rsum8, rsum12, rsum16
);

  localparam logic signed [23:0] LIM_POS = 24'(LIMIT);
  localparam logic signed [23:0] LIM_NEG = -LIM_POS;

  // Negative values floor at 0, anything above 255 ceilings at 255.
  function automatic logic [7:0] sat_u8(input logic signed [23:0] v);
    if (v[23])
      return 8'd0;
    else if (v > 24'sd255)
      return 8'hFF;
    else
      return v[7:0];
  endfunction

  logic signed [7:0]  a_port [4];
  logic signed [7:0]  w_port [4][4];
  logic signed [7:0]  wreg   [4][4];
  logic signed [7:0]  aout   [4][4];
  logic signed [7:0]  a_in   [4][4];
  logic signed [23:0] pout   [4][4];
  logic signed [23:0] p_in   [4][4];
  logic signed [23:0] prod_x [4][4];

  assign a_port[0] = a11;
  assign a_port[1] = a12;
  assign a_port[2] = a13;
  assign a_port[3] = a14;

  assign w_port[0][0] = w11; assign w_port[0][1] = w12; assign w_port[0][2] = w13; assign w_port[0][3] = w14;
  assign w_port[1][0] = w21; assign w_port[1][1] = w22; assign w_port[1][2] = w23; assign w_port[1][3] = w24;
  assign w_port[2][0] = w31; assign w_port[2][1] = w32; assign w_port[2][2] = w33; assign w_port[2][3] = w34;
  assign w_port[3][0] = w41; assign w_port[3][1] = w42; assign w_port[3][2] = w43; assign w_port[3][3] = w44;

  // PE interconnect: activations move right, partial sums move down.
  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < 4; c++) begin : g_col
      logic signed [15:0] prod;

      if (c == 0) begin : g_first_col
        assign a_in[r][c] = a_port[r];
      end else begin : g_inner_col
        assign a_in[r][c] = aout[r][c-1];
      end

      if (r == 0) begin : g_top_row
        assign p_in[r][c] = carry_in;
      end else begin : g_inner_row
        assign p_in[r][c] = pout[r-1][c];
      end

      assign prod         = a_in[r][c] * wreg[r][c];
      assign prod_x[r][c] = {{8{prod[15]}}, prod};
    end
  end

  // All PE registers: async clear, otherwise load weight, pass activation, accumulate.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 4; c++) begin
          wreg[r][c] <= '0;
          aout[r][c] <= '0;
          pout[r][c] <= '0;
        end
      end
    end else begin
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 4; c++) begin
          wreg[r][c] <= w_port[r][c];
          aout[r][c] <= a_in[r][c];
          pout[r][c] <= p_in[r][c] + prod_x[r][c];
        end
      end
    end
  end

  logic signed [23:0] sum_a [4];
  logic signed [23:0] lim_a [4];
  logic signed [23:0] act_a [4];
  logic        [7:0]  q_a   [4];
  logic        [7:0]  rs_a  [4];

  // Per-column combinational post-processing of the bottom-row sum.
  for (genvar c = 0; c < 4; c++) begin : g_post
    logic signed [23:0] shifted;

    assign sum_a[c] = pout[3][c];
    assign q_a[c]   = sat_u8(sum_a[c]);
    assign lim_a[c] = (sum_a[c] > LIM_POS) ? LIM_POS :
                      (sum_a[c] < LIM_NEG) ? LIM_NEG : sum_a[c];
`ifdef RELU_EN
    assign act_a[c] = lim_a[c][23] ? 24'sd0 : lim_a[c];
`else
    assign act_a[c] = lim_a[c];
`endif
    assign shifted  = act_a[c] >>> RSHIFT;
    assign rs_a[c]  = sat_u8(shifted);
  end

  assign sum4  = sum_a[0]; assign sum8  = sum_a[1]; assign sum12 = sum_a[2]; assign sum16 = sum_a[3];
  assign qsum4 = q_a[0];   assign qsum8 = q_a[1];   assign qsum12 = q_a[2];  assign qsum16 = q_a[3];
  assign limited_sum4   = lim_a[0]; assign limited_sum8   = lim_a[1];
  assign limited_sum12  = lim_a[2]; assign limited_sum16  = lim_a[3];
  assign activated_sum4 = act_a[0]; assign activated_sum8 = act_a[1];
  assign activated_sum12 = act_a[2]; assign activated_sum16 = act_a[3];
  assign rsum4 = rs_a[0];  assign rsum8 = rs_a[1];  assign rsum12 = rs_a[2];  assign rsum16 = rs_a[3];

endmodule
`default_nettype wire

// File: tb/tb_test_systolic_mac.sv
`default_nettype none
// ============================================================================
// Module      : tb_test_systolic_mac
// Description : Directed, table-driven bench for test_systolic_mac. Honors
//               RELU_EN for the activated_sum expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_test_systolic_mac;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic signed [7:0]  a [4];
  logic signed [7:0]  w [4][4];
  logic signed [23:0] carry_in;
  logic signed [23:0] sum [4];
  logic        [7:0]  q   [4];
  logic signed [23:0] lim [4];
  logic signed [23:0] act [4];
  logic        [7:0]  rs  [4];

  always #5 clock = ~clock;

  test_systolic_mac dut (
    .clock(clock), .reset(reset),
    .a11(a[0]), .a12(a[1]), .a13(a[2]), .a14(a[3]),
    .w11(w[0][0]), .w12(w[0][1]), .w13(w[0][2]), .w14(w[0][3]),
    .w21(w[1][0]), .w22(w[1][1]), .w23(w[1][2]), .w24(w[1][3]),
    .w31(w[2][0]), .w32(w[2][1]), .w33(w[2][2]), .w34(w[2][3]),
    .w41(w[3][0]), .w42(w[3][1]), .w43(w[3][2]), .w44(w[3][3]),
    .carry_in(carry_in),
    .sum4(sum[0]), .sum8(sum[1]), .sum12(sum[2]), .sum16(sum[3]),
    .qsum4(q[0]), .qsum8(q[1]), .qsum12(q[2]), .qsum16(q[3]),
    .limited_sum4(lim[0]), .limited_sum8(lim[1]), .limited_sum12(lim[2]), .limited_sum16(lim[3]),
    .activated_sum4(act[0]), .activated_sum8(act[1]), .activated_sum12(act[2]), .activated_sum16(act[3]),
    .rsum4(rs[0]), .rsum8(rs[1]), .rsum12(rs[2]), .rsum16(rs[3])
  );

  typedef struct packed {
    logic [3:0][7:0]  vec;
    logic [3:0][7:0]  wcol;
    logic [31:0]      carry;
    logic [3:0][31:0] sum;
    logic [3:0][31:0] q;
    logic [3:0][31:0] lim;
    logic [3:0][31:0] rs;
  } rec_t;

  rec_t            tbl [7];
  logic [3:0][7:0] vecs [8];
  int              nv;
  int              checks = 0;
  int              errors = 0;

  function automatic logic [3:0][7:0] p8(input int x0, input int x1, input int x2, input int x3);
    logic [3:0][7:0] v;
    v[0] = x0[7:0]; v[1] = x1[7:0]; v[2] = x2[7:0]; v[3] = x3[7:0];
    return v;
  endfunction

  function automatic logic [3:0][31:0] p32(input int x0, input int x1, input int x2, input int x3);
    logic [3:0][31:0] v;
    v[0] = x0; v[1] = x1; v[2] = x2; v[3] = x3;
    return v;
  endfunction

  function automatic rec_t mk(input logic [3:0][7:0] vec, input logic [3:0][7:0] wcol, input int carry,
                              input logic [3:0][31:0] s, input logic [3:0][31:0] qq,
                              input logic [3:0][31:0] l, input logic [3:0][31:0] r);
    rec_t x;
    x.vec = vec; x.wcol = wcol; x.carry = carry; x.sum = s; x.q = qq; x.lim = l; x.rs = r;
    return x;
  endfunction

  function automatic int act_exp(input int l);
`ifdef RELU_EN
    return (l < 0) ? 0 : l;
`else
    return l;
`endif
  endfunction

  task automatic chk(input string nm, input int col, input int actual, input int required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("FAIL %s col%0d actual=%0d required=%0d (t=%0t)", nm, col + 1, actual, required, $time);
    end
  endtask

  task automatic check_col(input int c, input int s, input int qv, input int lv, input int rv);
    chk("sum", c, int'(sum[c]), s);
    chk("qsum", c, int'(q[c]), qv);
    chk("limited_sum", c, int'(lim[c]), lv);
    chk("activated_sum", c, int'(act[c]), act_exp(lv));
    chk("rsum", c, int'(rs[c]), rv);
  endtask

  task automatic check_all_zero(input string nm);
    for (int c = 0; c < 4; c++) begin
      chk({nm, "_sum"}, c, int'(sum[c]), 0);
      chk({nm, "_qsum"}, c, int'(q[c]), 0);
      chk({nm, "_lim"}, c, int'(lim[c]), 0);
      chk({nm, "_act"}, c, int'(act[c]), 0);
      chk({nm, "_rsum"}, c, int'(rs[c]), 0);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Skewed feeder: row r sees vector k at cycle k + r.
  task automatic drive(input int t);
    for (int r = 0; r < 4; r++) begin
      int idx;
      idx = t - r;
      if (idx >= 0 && idx < nv) a[r] = vecs[idx][r];
      else                      a[r] = 8'sd0;
    end
  endtask

  task automatic set_weights(input logic [3:0][7:0] wcol);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        w[r][c] = wcol[c];
  endtask

  task automatic zero_a();
    for (int r = 0; r < 4; r++) a[r] = 8'sd0;
  endtask

  int e4  [4] = '{16, 9, 6, 3};
  int e8  [4] = '{32, 18, 12, 6};
  int e16 [4] = '{64, 36, 24, 12};

  initial begin
    zero_a();
    set_weights(p8(0, 0, 0, 0));
    carry_in = 24'sd0;
    nv = 0;

    tbl[0] = mk(p8(4, 4, 4, 4), p8(1, 2, 3, 4), 0,
                p32(16, 32, 48, 64), p32(16, 32, 48, 64), p32(16, 32, 48, 64), p32(4, 8, 12, 16));
    tbl[1] = mk(p8(1, 1, 1, 1), p8(1, 1, 1, 1), 100,
                p32(104, 104, 104, 104), p32(104, 104, 104, 104), p32(104, 104, 104, 104), p32(26, 26, 26, 26));
    tbl[2] = mk(p8(127, 127, 127, 127), p8(127, 127, 127, 127), 0,
                p32(64516, 64516, 64516, 64516), p32(255, 255, 255, 255),
                p32(32767, 32767, 32767, 32767), p32(255, 255, 255, 255));
    tbl[3] = mk(p8(-1, -1, -1, -1), p8(5, 5, 5, 5), 0,
                p32(-20, -20, -20, -20), p32(0, 0, 0, 0), p32(-20, -20, -20, -20), p32(0, 0, 0, 0));
    tbl[4] = mk(p8(0, 3, 3, 3), p8(1, 2, 3, 4), 0,
                p32(9, 18, 27, 36), p32(9, 18, 27, 36), p32(9, 18, 27, 36), p32(2, 4, 6, 9));
    tbl[5] = mk(p8(2, -3, 1, 5), p8(1, -2, 3, 0), 0,
                p32(5, -10, 15, 0), p32(5, 0, 15, 0), p32(5, -10, 15, 0), p32(1, 0, 3, 0));
    tbl[6] = mk(p8(0, 0, 0, 0), p8(1, 1, 1, 1), -40000,
                p32(-40000, -40000, -40000, -40000), p32(0, 0, 0, 0),
                p32(-32767, -32767, -32767, -32767), p32(0, 0, 0, 0));

    // Asynchronous reset from the start, then release between edges.
    #2 reset = 1'b1;
    #1 check_all_zero("reset");
    tick();
    #2 reset = 1'b0;
    tick();

    // Single-vector records; column c result lands 3 + c edges after entry.
    for (int i = 0; i < 7; i++) begin
      set_weights(tbl[i].wcol);
      carry_in = 24'(tbl[i].carry);
      zero_a();
      tick();
      tick();
      nv = 1;
      vecs[0] = tbl[i].vec;
      for (int t = 0; t < 8; t++) begin
        drive(t);
        tick();
        if (t >= 3 && t <= 6)
          check_col(t - 3, $signed(tbl[i].sum[t-3]), $signed(tbl[i].q[t-3]),
                    $signed(tbl[i].lim[t-3]), $signed(tbl[i].rs[t-3]));
      end
    end

    // Reset mid-cycle clears nonzero state without a clock edge.
    @(negedge clock);
    reset = 1'b1;
    #1 check_all_zero("async_reset");
    zero_a();
    carry_in = 24'sd0;
    set_weights(p8(1, 2, 3, 4));
    #2 reset = 1'b0;
    for (int t = 0; t < 3; t++) tick();
    check_all_zero("post_release");

    // Back-to-back basic matmul with row skew.
    vecs[0] = p8(4, 4, 4, 4);
    vecs[1] = p8(0, 3, 3, 3);
    vecs[2] = p8(2, 2, 0, 2);
    vecs[3] = p8(1, 0, 1, 1);
    nv = 4;
    for (int t = 0; t < 11; t++) begin
      drive(t);
      tick();
      if (t >= 3 && t <= 6) begin
        chk("b2b_sum4", 0, int'(sum[0]), e4[t-3]);
        chk("b2b_qsum4", 0, int'(q[0]), e4[t-3]);
      end
      if (t >= 4 && t <= 7) chk("b2b_sum8", 1, int'(sum[1]), e8[t-4]);
      if (t >= 6 && t <= 9) begin
        chk("b2b_sum16", 3, int'(sum[3]), e16[t-6]);
        chk("b2b_qsum16", 3, int'(q[3]), e16[t-6]);
        chk("b2b_rsum16", 3, int'(rs[3]), e4[t-6]);
      end
    end

    // Reset two edges into the stream: in-flight sums must not survive.
    zero_a();
    tick();
    tick();
    for (int t = 0; t < 2; t++) begin
      drive(t);
      tick();
    end
    #2 reset = 1'b1;
    #1;
    for (int c = 0; c < 4; c++) chk("midrst_sum", c, int'(sum[c]), 0);
    zero_a();
    tick();
    #2 reset = 1'b0;
    for (int t = 0; t < 2; t++) begin
      tick();
      chk("midrst_idle_sum4", 0, int'(sum[0]), 0);
      chk("midrst_idle_sum16", 3, int'(sum[3]), 0);
    end
    vecs[0] = p8(1, 0, 1, 1);
    nv = 1;
    for (int t = 0; t < 8; t++) begin
      drive(t);
      tick();
      if (t <= 6) chk("midrst_sum4", 0, int'(sum[0]), (t == 3) ? 3 : 0);
      chk("midrst_sum16", 3, int'(sum[3]), (t == 6) ? 12 : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
